pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 63 ++++++
 tb/tb_pc_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program counter with relative/absolute/link jumps and a post-jump flush window.
module pc_sequencer #(
  parameter logic [19:0] RESET_PC = 20'h00000,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  pcjumpenable,
  input  logic [8:0]  pcchange,
  input  logic [5:0]  pclocation,
  input  logic        stall,
  input  logic        fetch_ready,
  output logic [19:0] programcounter,
  output logic        fetch_valid,
  output logic        flush,
  output logic [19:0] previous_programcounter,
  output logic        link_valid
);
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [19:0] pc_n, prev_n, target;
  logic fv_n, flush_n, link_n, jump, hs;
  // Codes 4-7 are reserved and ignored; nothing is sampled during BOOT.
  assign jump = state != BOOT && pcjumpenable != 3'd0 && !pcjumpenable[2];
  assign hs = fetch_valid && fetch_ready;
  assign target = pcjumpenable == 3'd1 ? programcounter + {{11{pcchange[8]}}, pcchange}
                                       : {14'b0, pclocation};
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= BOOT;
      cnt <= 3'd0;
      programcounter <= RESET_PC;
      previous_programcounter <= 20'h0;
      fetch_valid <= 1'b0;
      flush <= 1'b0;
      link_valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      programcounter <= pc_n;
      previous_programcounter <= prev_n;
      fetch_valid <= fv_n;
      flush <= flush_n;
      link_valid <= link_n;
    end
  end
  // cnt holds the flush cycles remaining including the current one.
  always_comb begin
    state_n = jump ? FLUSH
            : state == BOOT ? RUN
            : state == FLUSH && cnt == 3'd1 ? RUN
            : state;
    cnt_n = jump ? 3'(FLUSH_CYCLES) : state == FLUSH ? cnt - 3'd1 : 3'd0;
  end
  always_comb begin
    pc_n = jump ? target : hs ? programcounter + 20'd1 : programcounter;
    link_n = jump && pcjumpenable == 3'd3;
    prev_n = link_n ? programcounter + 20'd1 : previous_programcounter;
    fv_n = state_n == RUN && !stall;
    flush_n = state_n == FLUSH;
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random checks of pc_sequencer against a cycle-level reference model.
module tb_pc_sequencer;
  localparam int F = 2;
  logic clock = 1'b0, reset = 1'b1, stall = 1'b0, fetch_ready = 1'b0;
  logic [2:0] pcjumpenable = 3'd0;
  logic [8:0] pcchange = 9'd0;
  logic [5:0] pclocation = 6'd0;
  logic [19:0] programcounter, previous_programcounter, saved;
  logic fetch_valid, flush, link_valid;
  int total = 0, bad = 0;
  logic [19:0] m_pc, m_prev;
  logic m_fv, m_flush, m_link, m_boot;
  int m_left;

  always #5 clock = ~clock;

  pc_sequencer #(.RESET_PC(20'h00000), .FLUSH_CYCLES(F)) dut (
    .clock(clock), .reset(reset), .pcjumpenable(pcjumpenable), .pcchange(pcchange),
    .pclocation(pclocation), .stall(stall), .fetch_ready(fetch_ready),
    .programcounter(programcounter), .fetch_valid(fetch_valid), .flush(flush),
    .previous_programcounter(previous_programcounter), .link_valid(link_valid)
  );

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] j, input logic [8:0] c,
                      input logic [5:0] l, input logic s, input logic fr);
    logic tk, hs;
    reset = r; pcjumpenable = j; pcchange = c; pclocation = l; stall = s; fetch_ready = fr;
    @(posedge clock);
    if (r) begin
      m_pc = 20'h0; m_prev = 20'h0; m_fv = 0; m_flush = 0; m_link = 0; m_boot = 1; m_left = 0;
    end else begin
      tk = !m_boot && j >= 3'd1 && j <= 3'd3;
      hs = m_fv && fr;
      m_link = tk && j == 3'd3;
      if (m_link) m_prev = m_pc + 20'd1;
      if (tk) begin
        m_pc = (j == 3'd1) ? m_pc + 20'($signed(c)) : 20'(l);
        m_left = F;
      end else begin
        if (hs) m_pc = m_pc + 20'd1;
        if (m_left > 0) m_left--;
      end
      m_boot = 0;
      m_flush = m_left > 0;
      m_fv = !m_flush && !s;
    end
    #1;
    chk("pc", programcounter, m_pc);
    chk("prev", previous_programcounter, m_prev);
    chk("fetch_valid", 20'(fetch_valid), 20'(m_fv));
    chk("flush", 20'(flush), 20'(m_flush));
    chk("link_valid", 20'(link_valid), 20'(m_link));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 3'd0, 9'd0, 6'd0, 0, 1);
  endtask

  initial begin
    step(1, 3'd2, 9'd0, 6'h15, 0, 1);
    step(1, 3'd0, 9'd0, 6'd0, 0, 1);
    chk("rst_pc", programcounter, 20'h0);
    chk("rst_fv", 20'(fetch_valid), 20'h0);
    // boot cycle ends, fetching begins
    idle(1);
    chk("boot_fv", 20'(fetch_valid), 20'h1);
    chk("seq0", programcounter, 20'h0);
    idle(3);
    chk("seq3", programcounter, 20'h3);
    step(0, 3'd2, 9'd0, 6'h10, 0, 1);
    idle(2);
    chk("at10", programcounter, 20'h10);
    step(0, 3'd1, 9'h1F8, 6'd0, 0, 1);
    chk("rel_m8", programcounter, 20'h8);
    chk("rel_flush", 20'(flush), 20'h1);
    idle(1);
    chk("rel_flush2", 20'(flush), 20'h1);
    chk("rel_fv2", 20'(fetch_valid), 20'h0);
    idle(1);
    chk("rel_run", 20'(fetch_valid), 20'h1);
    step(0, 3'd2, 9'd0, 6'h05, 0, 1);
    idle(2);
    step(0, 3'd3, 9'd0, 6'h2A, 0, 0);
    chk("link_pc", programcounter, 20'h2A);
    chk("link_prev", previous_programcounter, 20'h6);
    chk("link_pulse", 20'(link_valid), 20'h1);
    idle(1);
    chk("link_end", 20'(link_valid), 20'h0);
    idle(2);
    step(0, 3'd2, 9'd0, 6'h00, 0, 1);
    step(0, 3'd1, 9'h1FF, 6'd0, 0, 1);
    chk("wrap_neg", programcounter, 20'hFFFFF);
    idle(2);
    chk("at_max", programcounter, 20'hFFFFF);
    idle(1);
    chk("wrap_inc", programcounter, 20'h0);
    step(0, 3'd2, 9'd0, 6'h02, 0, 1);
    step(0, 3'd1, 9'h1FC, 6'd0, 0, 1);
    chk("wrap_rel", programcounter, 20'hFFFFE);
    idle(3);
    step(0, 3'd2, 9'd0, 6'h3F, 0, 1);
    step(0, 3'd2, 9'd0, 6'h10, 0, 1);
    chk("retarget", programcounter, 20'h10);
    idle(1);
    chk("retarget_fl", 20'(flush), 20'h1);
    idle(1);
    chk("retarget_end", 20'(flush), 20'h0);
    step(0, 3'd0, 9'd0, 6'd0, 1, 1);
    saved = programcounter;
    for (int i = 0; i < 3; i++) begin
      step(0, 3'd0, 9'd0, 6'd0, 1, 1);
      chk("stall_pc", programcounter, saved);
      chk("stall_fv", 20'(fetch_valid), 20'h0);
    end
    step(0, 3'd3, 9'd0, 6'h21, 1, 1);
    step(1, 3'd1, 9'h033, 6'd0, 0, 1);
    chk("midfl_pc", programcounter, 20'h0);
    chk("midfl_flush", 20'(flush), 20'h0);
    chk("midfl_prev", previous_programcounter, 20'h0);
    for (int i = 0; i < 500; i++) begin
      logic [2:0] j;
      j = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      step($urandom_range(0, 49) == 0, j, 9'($urandom), 6'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
